// File: rtl/bsmac_pkg.sv
// bsmac_pkg: shared types and helpers for the bit-serial MAC array.
//   state_e      - controller states (IDLE, RUN, DONE)
//   PREC_*       - precision-level encodings carried on in_prec
//   prec_nbits() - number of weight bits processed for a precision level
package bsmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] PREC_FULL    = 2'd0;
  localparam logic [1:0] PREC_HALF    = 2'd1;
  localparam logic [1:0] PREC_QUARTER = 2'd2;
  localparam logic [1:0] PREC_EIGHTH  = 2'd3;

  // Weight bits consumed per transaction: WGT_W, WGT_W/2, WGT_W/4 or WGT_W/8.
  function automatic int prec_nbits(input int wgt_w, input logic [1:0] prec);
    case (prec)
      PREC_FULL:    prec_nbits = wgt_w;
      PREC_HALF:    prec_nbits = wgt_w / 2;
      PREC_QUARTER: prec_nbits = wgt_w / 4;
      PREC_EIGHTH:  prec_nbits = wgt_w / 8;
      default:      prec_nbits = wgt_w;
    endcase
  endfunction

endpackage

// File: rtl/bit_serial_mac_array_lane_reduce.sv
// bsmac_lane_reduce: combinational partial-product stage.
// Each lane's activation is gated by that lane's current weight bit and the
// gated values are summed across all lanes.
//   act  in  LANES*ACT_W           activations, lane i at [i*ACT_W +: ACT_W]
//   wbit in  LANES                 current weight bit per lane
//   p    out ACT_W+clog2(LANES)    sum of gated activations (cannot overflow)
module bsmac_lane_reduce #(
  parameter int LANES = 4,
  parameter int ACT_W = 8,
  parameter int PW    = ACT_W + $clog2(LANES)
) (
  input  logic [LANES*ACT_W-1:0] act,
  input  logic [LANES-1:0]       wbit,
  output logic [PW-1:0]          p
);

  // Gate and sum lanes; PW is sized so LANES full-scale activations fit.
  always_comb begin
    p = {PW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (wbit[i]) begin
        p = p + PW'(act[i*ACT_W +: ACT_W]);
      end else begin
        p = p + {PW{1'b0}};
      end
    end
  end

endmodule

// File: rtl/bit_serial_mac_array.sv
// bit_serial_mac_array: LANES activation/weight pairs multiplied bit-serially
// (one weight bit per cycle, LSB first) and reduced into one accumulator.
// Optional build macro: SIGNED_WEIGHT_EN - weights are two's complement at the
// selected precision (MSB partial product is subtracted).
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset
//   in_valid  in  operand vector valid
//   in_ready  out block can accept an operand vector (IDLE)
//   in_act    in  LANES*ACT_W activations
//   in_wgt    in  LANES*WGT_W weights
//   in_prec   in  precision level 0..3 -> WGT_W >> in_prec bits
//   in_clr    in  1 = start from zero, 0 = add onto held accumulator
//   out_valid out result held in out_acc
//   out_ready in  downstream accepts result
//   out_acc   out accumulator (modulo 2^ACC_W)
//   busy      out controller not in IDLE
//   bit_cnt   out current weight bit index (debug)
module bit_serial_mac_array
  import bsmac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACT_W = 8,
  parameter int WGT_W = 8,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACT_W-1:0]   in_act,
  input  logic [LANES*WGT_W-1:0]   in_wgt,
  input  logic [1:0]               in_prec,
  input  logic                     in_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_acc,
  output logic                     busy,
  output logic [$clog2(WGT_W)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(WGT_W);
  localparam int NW    = CNT_W + 1;
  localparam int PW    = ACT_W + $clog2(LANES);

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [LANES*ACT_W-1:0] act_r;
  logic [LANES*WGT_W-1:0] wgt_r;
  logic [NW-1:0]          nbits_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [ACC_W-1:0]       acc_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic                   busy_r;

  logic                   accept_s;
  logic                   last_s;
  logic [WGT_W-1:0]       wgt_lane_s [LANES];
  logic [LANES-1:0]       wbit_s;
  logic [PW-1:0]          p_s;
  logic [ACC_W-1:0]       term_s;
  logic [ACC_W-1:0]       acc_nxt_s;

  assign accept_s = in_valid && (state_r == IDLE);
  assign last_s   = (state_r == RUN) &&
                    ({1'b0, bit_cnt_r} == (nbits_r - {{CNT_W{1'b0}}, 1'b1}));

  // Only bits below N are ever indexed, so upper weight bits are ignored.
  for (genvar g = 0; g < LANES; g++) begin : g_wbit
    assign wgt_lane_s[g] = wgt_r[g*WGT_W +: WGT_W];
    assign wbit_s[g]     = wgt_lane_s[g][bit_cnt_r];
  end

  bsmac_lane_reduce #(
    .LANES (LANES),
    .ACT_W (ACT_W),
    .PW    (PW)
  ) u_reduce (
    .act  (act_r),
    .wbit (wbit_s),
    .p    (p_s)
  );

  assign term_s = ACC_W'(p_s) << bit_cnt_r;

  // Accumulator update; in signed mode the weight MSB carries negative weight.
  always_comb begin
    acc_nxt_s = acc_r + term_s;
`ifdef SIGNED_WEIGHT_EN
    if (last_s) begin
      acc_nxt_s = acc_r - term_s;
    end else begin
      acc_nxt_s = acc_r + term_s;
    end
`else
    acc_nxt_s = acc_r + term_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      act_r       <= {(LANES*ACT_W){1'b0}};
      wgt_r       <= {(LANES*WGT_W){1'b0}};
      nbits_r     <= {NW{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            act_r     <= in_act;
            wgt_r     <= in_wgt;
            nbits_r   <= NW'(prec_nbits(WGT_W, in_prec));
            bit_cnt_r <= {CNT_W{1'b0}};
            if (in_clr) acc_r <= {ACC_W{1'b0}};
          end
        end
        RUN: begin
          acc_r     <= acc_nxt_s;
          // Park the debug counter at zero once the last bit is consumed.
          bit_cnt_r <= last_s ? {CNT_W{1'b0}} : bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          bit_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_acc   = acc_r;
  assign bit_cnt   = bit_cnt_r;

endmodule

// File: tb/tb_bit_serial_mac_array.sv
// Self-checking bench for bit_serial_mac_array (LANES=4, ACT_W=8, WGT_W=8,
// ACC_W=24). Expected results are pushed to a scoreboard queue at accept
// time and popped when the result is presented.
module tb_bit_serial_mac_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_act;
  logic [31:0] in_wgt;
  logic [1:0]  in_prec;
  logic        in_clr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_acc;
  logic        busy;
  logic [2:0]  bit_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] sb_q[$];
  logic [23:0] model_acc;

  typedef struct {
    logic [31:0] act;
    logic [31:0] wgt;
    logic [1:0]  prec;
    logic        clr;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  bit_serial_mac_array #(
    .LANES (4),
    .ACT_W (8),
    .WGT_W (8),
    .ACC_W (24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .in_prec   (in_prec),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .busy      (busy),
    .bit_cnt   (bit_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference dot product built from integer multiplies on masked weights.
  function automatic logic [23:0] model_sum(input logic [31:0] act, input logic [31:0] wgt,
                                            input logic [1:0] prec);
    int    n;
    longint s;
    longint a;
    longint w;
    n = 8 >> prec;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a = longint'(act[i*8 +: 8]);
      w = longint'(wgt[i*8 +: 8]) & ((64'sd1 <<< n) - 1);
`ifdef SIGNED_WEIGHT_EN
      if (w >= (64'sd1 <<< (n - 1))) w = w - (64'sd1 <<< n);
`endif
      s = s + a * w;
    end
    return s[23:0];
  endfunction

  // Present one operand vector, push its expected result, step past accept.
  task automatic send(input string tag, input logic [31:0] act, input logic [31:0] wgt,
                      input logic [1:0] prec, input logic clr, input logic [23:0] exp);
    @(negedge clk);
    check($sformatf("%s.in_ready", tag), {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_act   = act;
    in_wgt   = wgt;
    in_prec  = prec;
    in_clr   = clr;
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    in_prec  = ~prec;
    in_clr   = ~clr;
  endtask

  // Wait (bounded) for out_valid; check bit_cnt sweep and latency.
  task automatic wait_valid(input string tag, input logic [1:0] prec);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check($sformatf("%s.bit_cnt", tag), {29'd0, bit_cnt}, (lat - 1) & 7);
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s.latency", tag), lat, (8 >> prec) + 1);
  endtask

  // Compare result against scoreboard and complete the output handshake.
  task automatic collect(input string tag);
    logic [23:0] e;
    e = 24'hxxxxxx;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check($sformatf("%s.out_valid", tag), {31'd0, out_valid}, 32'd1);
    check($sformatf("%s.out_acc", tag), {8'd0, out_acc}, {8'd0, e});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s.post_valid", tag), {31'd0, out_valid}, 32'd0);
    check($sformatf("%s.post_ready", tag), {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] act, input logic [31:0] wgt,
                         input logic [1:0] prec, input logic clr, input logic [23:0] exp);
    send(tag, act, wgt, prec, clr, exp);
    wait_valid(tag, prec);
    collect(tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rw;
    logic [1:0]  rp;
    logic        rc;
    int          guard;
    logic [23:0] held;

    rst = 1'b1; in_valid = 1'b0; in_act = 32'd0; in_wgt = 32'd0;
    in_prec = 2'd0; in_clr = 1'b0; out_ready = 1'b0;

`ifdef SIGNED_WEIGHT_EN
    vecs[0] = '{32'h0000000B, 32'h00000009, 2'd0, 1'b1, 24'd99};
    vecs[1] = '{32'h0000000B, 32'h00000055, 2'd1, 1'b1, 24'd55};
    vecs[2] = '{32'h0000000B, 32'h00000009, 2'd1, 1'b1, 24'hFFFFB3};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 1'b1, 24'hFFFC04};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 1'b1, 24'hFFFC04};
    vecs[5] = '{32'h0000000B, 32'h00000009, 2'd0, 1'b1, 24'd99};
    vecs[6] = '{32'h0000000B, 32'h00000055, 2'd1, 1'b0, 24'd154};
    vecs[7] = '{32'h01020304, 32'hF3F2F1F0, 2'd2, 1'b1, 24'hFFFFFE};
    vecs[8] = '{32'h00000000, 32'hFFFFFFFF, 2'd0, 1'b1, 24'd0};
`else
    vecs[0] = '{32'h0000000B, 32'h00000009, 2'd0, 1'b1, 24'd99};
    vecs[1] = '{32'h0000000B, 32'h00000055, 2'd1, 1'b1, 24'd55};
    vecs[2] = '{32'h0000000B, 32'h00000009, 2'd1, 1'b1, 24'd99};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 1'b1, 24'd260100};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 1'b1, 24'd1020};
    vecs[5] = '{32'h0000000B, 32'h00000009, 2'd0, 1'b1, 24'd99};
    vecs[6] = '{32'h0000000B, 32'h00000055, 2'd1, 1'b0, 24'd154};
    vecs[7] = '{32'h01020304, 32'hF3F2F1F0, 2'd2, 1'b1, 24'd10};
    vecs[8] = '{32'h00000000, 32'hFFFFFFFF, 2'd0, 1'b1, 24'd0};
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.out_acc", {8'd0, out_acc}, 32'd0);
    check("rst.bit_cnt", {29'd0, bit_cnt}, 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].act, vecs[i].wgt, vecs[i].prec,
              vecs[i].clr, vecs[i].exp);
      model_acc = vecs[i].exp;
    end

    // Backpressure: result held, in_ready low, extra in_valid ignored.
    model_acc = model_sum(32'h00000A0B, 32'h00000306, 2'd0);
    send("bp", 32'h00000A0B, 32'h00000306, 2'd0, 1'b1, model_acc);
    in_valid = 1'b1;
    in_act   = 32'hFFFFFFFF;
    in_wgt   = 32'hFFFFFFFF;
    wait_valid("bp", 2'd0);
    held = out_acc;
    for (int c = 0; c < 5; c++) begin
      check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp.hold_acc", {8'd0, out_acc}, {8'd0, model_acc});
      check("bp.hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp.stable", {8'd0, out_acc}, {8'd0, held});
    in_valid = 1'b0;
    collect("bp");
    check("bp.busy", {31'd0, busy}, 32'd0);
    model_acc = model_acc + model_sum(32'h00000001, 32'h00000001, 2'd0);
    run_txn("bp.next", 32'h00000001, 32'h00000001, 2'd0, 1'b0, model_acc);

    // Reset in the middle of RUN at bit_cnt = 3.
    send("mrst", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 1'b1, 24'd0);
    guard = 0;
    while (bit_cnt != 3'd3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("mrst.reach3", {29'd0, bit_cnt}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst.out_acc", {8'd0, out_acc}, 32'd0);
    check("mrst.busy", {31'd0, busy}, 32'd0);
    check("mrst.bit_cnt", {29'd0, bit_cnt}, 32'd0);
    run_txn("mrst.after", 32'h0000000B, 32'h00000009, 2'd0, 1'b0, 24'd99);
    model_acc = 24'd99;

    // Random vectors against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rw = $urandom;
      rp = 2'($urandom_range(0, 3));
      rc = 1'($urandom_range(0, 1));
      model_acc = (rc ? 24'd0 : model_acc) + model_sum(ra, rw, rp);
      run_txn($sformatf("rnd%0d", i), ra, rw, rp, rc, model_acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
